// File: rtl/pipe_gap_gen_pkg.sv
// ---------------------------------------------------------------------------
// pipe_gap_gen_pkg
// Shared definitions for the pipe-gap generator: default geometry, the
// generator FSM state type and the LFSR feedback mask.
// Ports: none (package).
// ---------------------------------------------------------------------------
package pipe_gap_gen_pkg;

    localparam int DEF_NUM_PIPES   = 4;
    localparam int DEF_IW          = 2;
    localparam int DEF_YW          = 10;
    localparam int DEF_GAP         = 100;
    localparam int DEF_INIT_TOP    = 100;
    localparam int DEF_INIT_STRIDE = 50;
    localparam int DEF_MIN_TOP     = 40;
    localparam int DEF_MAX_TOP     = 300;
    localparam int DEF_MAX_STEP    = 120;

    localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;

    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right shift form)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRAW   = 3'd1,
        REDUCE = 3'd2,
        CLAMP  = 3'd3,
        WRITE  = 3'd4
    } state_t;

endpackage

// File: rtl/pipe_gap_gen_lfsr16.sv
// ---------------------------------------------------------------------------
// lfsr16
// Free-running 16-bit Galois LFSR used as the random source for gap heights.
// It advances on every clock and is only reloaded by rst.
// Ports:
//   clk  in   system clock
//   rst  in   asynchronous reset, active-high (loads SEED)
//   q    out  current LFSR state
// ---------------------------------------------------------------------------
module lfsr16
    import pipe_gap_gen_pkg::*;
#(
    parameter logic [15:0] SEED = DEF_LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    // Shift right every cycle; when a one falls out of bit 0 fold it back
    // through the tap mask.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= SEED;
        end else begin
            q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/pipe_gap_gen.sv
// ---------------------------------------------------------------------------
// pipe_gap_gen
// Holds the gap top/bottom Y edges of NUM_PIPES obstacles and regenerates one
// channel on request, either from a rotating table (mode 0) or from the LFSR
// limited to [MIN_TOP, MAX_TOP] and to MAX_STEP away from the previous
// channel (mode 1).
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous reset, active-high
//   start        in   synchronous reload of the initial table, aborts work
//   mode         in   0 = rotate table, 1 = random (sampled on accept)
//   respawn_req  in   level request, held until respawn_ack
//   respawn_idx  in   channel to regenerate, held with respawn_req
//   respawn_ack  out  one-cycle pulse, new edges visible this cycle
//   busy         out  high whenever the FSM is not idle
//   ytop_flat    out  top edges, channel i at [i*YW +: YW]
//   ybot_flat    out  bottom edges, same packing
// ---------------------------------------------------------------------------
module pipe_gap_gen
    import pipe_gap_gen_pkg::*;
#(
    parameter int          NUM_PIPES   = DEF_NUM_PIPES,
    parameter int          IW          = DEF_IW,
    parameter int          YW          = DEF_YW,
    parameter int          GAP         = DEF_GAP,
    parameter int          INIT_TOP    = DEF_INIT_TOP,
    parameter int          INIT_STRIDE = DEF_INIT_STRIDE,
    parameter int          MIN_TOP     = DEF_MIN_TOP,
    parameter int          MAX_TOP     = DEF_MAX_TOP,
    parameter int          MAX_STEP    = DEF_MAX_STEP,
    parameter logic [15:0] LFSR_SEED   = DEF_LFSR_SEED
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    mode,
    input  logic                    respawn_req,
    input  logic [IW-1:0]           respawn_idx,
    output logic                    respawn_ack,
    output logic                    busy,
    output logic [NUM_PIPES*YW-1:0] ytop_flat,
    output logic [NUM_PIPES*YW-1:0] ybot_flat
);

    localparam logic [YW:0] RANGE_W   = (YW+1)'(MAX_TOP - MIN_TOP);
    localparam logic [YW:0] RANGE1_W  = (YW+1)'(MAX_TOP - MIN_TOP + 1);
    localparam logic [YW:0] MIN_W     = (YW+1)'(MIN_TOP);
    localparam logic [YW:0] MAX_W     = (YW+1)'(MAX_TOP);
    localparam logic [YW:0] STEP_W    = (YW+1)'(MAX_STEP);
    localparam logic [YW:0] GAP_W     = (YW+1)'(GAP);

    state_t          state_q;
    logic            busy_q;
    logic            ack_q;
    logic [IW-1:0]   idx_q;
    logic            mode_q;
    logic [IW-1:0]   rot_q;
    logic [YW:0]     cand_q;
    logic [YW-1:0]   top_q [NUM_PIPES];
    logic [YW-1:0]   bot_q [NUM_PIPES];

    logic [15:0]     lfsrQ;
    logic [31:0]     idxWide;
    logic [31:0]     prevWide;
    logic            idxValid;
    logic [YW:0]     prevTop;
    logic [YW:0]     stepHi;
    logic [YW:0]     candClamp_d;
    logic [YW:0]     rotCand;
    logic [YW:0]     writeTop_d;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) uLfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsrQ)
    );

    // Index bookkeeping is done in 32 bits so that a request index wider than
    // the channel count can be recognised as out of range and ignored.
    assign idxWide  = 32'(idx_q);
    assign idxValid = (idxWide < 32'(NUM_PIPES));
    assign prevWide = (idxWide == 32'd0) ? 32'(NUM_PIPES - 1) : (idxWide - 32'd1);

    // Table value for the rotating mode, and the value WRITE commits.
    assign rotCand    = (YW+1)'(INIT_TOP + 32'(rot_q) * INIT_STRIDE);
    assign writeTop_d = mode_q ? cand_q : rotCand;

    // Step limit against the wrap-around neighbour, then the absolute range.
    // One extra bit of headroom keeps prevTop + MAX_STEP from wrapping; the
    // lower bound is only taken when prevTop exceeds MAX_STEP, so the
    // subtraction cannot underflow.
    always_comb begin
        prevTop = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            if (prevWide == 32'(i)) begin
                prevTop = {1'b0, top_q[i]};
            end
        end
        stepHi      = prevTop + STEP_W;
        candClamp_d = cand_q;
        if (cand_q > stepHi) begin
            candClamp_d = stepHi;
        end else if ((cand_q + STEP_W) < prevTop) begin
            candClamp_d = prevTop - STEP_W;
        end
        if (candClamp_d < MIN_W) begin
            candClamp_d = MIN_W;
        end else if (candClamp_d > MAX_W) begin
            candClamp_d = MAX_W;
        end
    end

    // Generator FSM. start outranks everything and reloads the initial
    // table without acknowledging whatever was in flight. A request is never
    // taken in the ack cycle, so a requester still holding req while it sees
    // the ack does not trigger a second respawn.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            idx_q   <= '0;
            mode_q  <= 1'b0;
            rot_q   <= '0;
            cand_q  <= '0;
            for (int i = 0; i < NUM_PIPES; i++) begin
                top_q[i] <= YW'(INIT_TOP + i * INIT_STRIDE);
                bot_q[i] <= YW'(INIT_TOP + i * INIT_STRIDE + GAP);
            end
        end else if (start) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            rot_q   <= '0;
            for (int i = 0; i < NUM_PIPES; i++) begin
                top_q[i] <= YW'(INIT_TOP + i * INIT_STRIDE);
                bot_q[i] <= YW'(INIT_TOP + i * INIT_STRIDE + GAP);
            end
        end else begin
            ack_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (respawn_req && !ack_q) begin
                        idx_q   <= respawn_idx;
                        mode_q  <= mode;
                        busy_q  <= 1'b1;
                        state_q <= mode ? DRAW : WRITE;
                    end
                end
                DRAW: begin
                    cand_q  <= {1'b0, YW'(lfsrQ)};
                    state_q <= REDUCE;
                end
                REDUCE: begin
                    if (cand_q > RANGE_W) begin
                        cand_q <= cand_q - RANGE1_W;
                    end else begin
                        cand_q  <= cand_q + MIN_W;
                        state_q <= CLAMP;
                    end
                end
                CLAMP: begin
                    cand_q  <= candClamp_d;
                    state_q <= WRITE;
                end
                WRITE: begin
                    if (idxValid) begin
                        for (int i = 0; i < NUM_PIPES; i++) begin
                            if (idxWide == 32'(i)) begin
                                top_q[i] <= YW'(writeTop_d);
                                bot_q[i] <= YW'(writeTop_d + GAP_W);
                            end
                        end
                        if (!mode_q) begin
                            rot_q <= (32'(rot_q) == 32'(NUM_PIPES - 1)) ? '0 : rot_q + 1'b1;
                        end
                    end
                    ack_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_PIPES; g++) begin : gFlat
            assign ytop_flat[g*YW +: YW] = top_q[g];
            assign ybot_flat[g*YW +: YW] = bot_q[g];
        end
    endgenerate

    assign respawn_ack = ack_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_pipe_gap_gen.sv
// ---------------------------------------------------------------------------
// tb_pipe_gap_gen
// Drives pipe_gap_gen with directed and random respawn requests and compares
// the edge table, handshake and latency against a reference model.
// The DUT is built with a 3-bit index so that out-of-range channels exist.
// ---------------------------------------------------------------------------
module tb_pipe_gap_gen;

    localparam int NP          = 4;
    localparam int IW          = 3;
    localparam int YW          = 10;
    localparam int GAP         = 100;
    localparam int INIT_TOP    = 100;
    localparam int INIT_STRIDE = 50;
    localparam int MIN_TOP     = 40;
    localparam int MAX_TOP     = 300;
    localparam int MAX_STEP    = 120;
    localparam int SPAN        = MAX_TOP - MIN_TOP + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              mode = 1'b0;
    logic              respawn_req = 1'b0;
    logic [IW-1:0]     respawn_idx = '0;
    logic              respawn_ack;
    logic              busy;
    logic [NP*YW-1:0]  ytop_flat;
    logic [NP*YW-1:0]  ybot_flat;

    int                checks = 0;
    int                errors = 0;
    int                mTop [NP];
    int                mRot;
    logic [15:0]       mLfsr;

    pipe_gap_gen #(
        .NUM_PIPES   (NP),
        .IW          (IW),
        .YW          (YW),
        .GAP         (GAP),
        .INIT_TOP    (INIT_TOP),
        .INIT_STRIDE (INIT_STRIDE),
        .MIN_TOP     (MIN_TOP),
        .MAX_TOP     (MAX_TOP),
        .MAX_STEP    (MAX_STEP),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode        (mode),
        .respawn_req (respawn_req),
        .respawn_idx (respawn_idx),
        .respawn_ack (respawn_ack),
        .busy        (busy),
        .ytop_flat   (ytop_flat),
        .ybot_flat   (ybot_flat)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Reference random source: the polynomial stepped once per clock from
    // the seed, independent of start.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mLfsr = 16'hACE1;
        end else begin
            mLfsr = mLfsr[0] ? ((mLfsr >> 1) ^ 16'hB400) : (mLfsr >> 1);
        end
    end

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic int dutTop(input int i);
        return int'(ytop_flat[i*YW +: YW]);
    endfunction

    function automatic int dutBot(input int i);
        return int'(ybot_flat[i*YW +: YW]);
    endfunction

    task automatic modelReload();
        for (int i = 0; i < NP; i++) begin
            mTop[i] = INIT_TOP + i * INIT_STRIDE;
        end
        mRot = 0;
    endtask

    task automatic checkTable(input string tag);
        for (int i = 0; i < NP; i++) begin
            checkOutput($sformatf("%s top%0d", tag, i), dutTop(i), mTop[i]);
            checkOutput($sformatf("%s bot%0d", tag, i), dutBot(i), mTop[i] + GAP);
        end
    endtask

    // One full respawn handshake. Expected top and latency come from the
    // rules: random draw folded into the legal range by modulo, step-limited
    // against the wrap-around neighbour, then range-limited.
    task automatic applyStimulus(input int idx, input bit m, input bit holdExtra);
        int  expTop;
        int  expLat;
        int  edges;
        int  prevI;
        int  p;
        int  raw;
        int  diff;
        bit  acked;
        @(negedge clk);
        respawn_req = 1'b1;
        respawn_idx = IW'(idx);
        mode        = m;
        @(posedge clk);
        #1;
        edges = 1;
        checkOutput("busyAfterAccept", int'(busy), 1);
        prevI = (idx == 0) ? NP - 1 : idx - 1;
        if (!m) begin
            expTop = INIT_TOP + mRot * INIT_STRIDE;
            expLat = 2;
        end else begin
            raw    = int'(mLfsr[YW-1:0]);
            expLat = 5 + raw / SPAN;
            expTop = raw % SPAN + MIN_TOP;
            p      = (idx < NP) ? mTop[prevI] : 0;
            if (expTop > p + MAX_STEP) begin
                expTop = p + MAX_STEP;
            end else if (expTop + MAX_STEP < p) begin
                expTop = p - MAX_STEP;
            end
            if (expTop < MIN_TOP) expTop = MIN_TOP;
            if (expTop > MAX_TOP) expTop = MAX_TOP;
        end
        acked = 1'b0;
        while (!acked && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
            if (respawn_ack) acked = 1'b1;
        end
        checkOutput("ackSeen", int'(acked), 1);
        checkOutput("latency", edges, expLat);
        checkOutput("busyAtAck", int'(busy), 0);
        if (idx < NP) begin
            if (m) begin
                checkOutput("topInRange",
                            int'(dutTop(idx) >= MIN_TOP && dutTop(idx) <= MAX_TOP), 1);
                diff = dutTop(idx) - mTop[prevI];
                if (diff < 0) diff = -diff;
                checkOutput("stepLimit", int'(diff <= MAX_STEP), 1);
            end else begin
                mRot = (mRot + 1) % NP;
            end
            mTop[idx] = expTop;
        end
        checkTable("respawn");
        if (holdExtra) begin
            @(posedge clk);
            #1;
            checkOutput("heldAckDrop", int'(respawn_ack), 0);
            checkOutput("heldNoAccept", int'(busy), 0);
        end
        respawn_req = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("ackOnePulse", int'(respawn_ack), 0);
        checkOutput("idleBusy", int'(busy), 0);
    endtask

    task automatic watchNoAck(input string tag, input int cycles);
        int acks;
        acks = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            if (respawn_ack) acks++;
        end
        checkOutput(tag, acks, 0);
    endtask

    // Stimulus sequence: reset, rotating table, out-of-range index, wrap
    // neighbour, random sweep, abort by start, abort by reset.
    initial begin
        int idx;
        int hold;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        modelReload();
        #1;
        checkTable("reset");
        checkOutput("resetBusy", int'(busy), 0);
        checkOutput("resetAck", int'(respawn_ack), 0);

        applyStimulus(2, 1'b0, 1'b0);
        applyStimulus(3, 1'b0, 1'b0);
        applyStimulus(5, 1'b0, 1'b1);
        applyStimulus(1, 1'b0, 1'b0);

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        modelReload();
        checkTable("startIdle");

        applyStimulus(0, 1'b1, 1'b0);
        checkOutput("wrapNeighbour", int'(dutTop(0) >= 130 && dutTop(0) <= 300), 1);

        for (int n = 0; n < 200; n++) begin
            idx  = int'($urandom_range(0, 5));
            hold = int'($urandom_range(0, 1));
            applyStimulus(idx, 1'b1, hold[0]);
        end

        @(negedge clk);
        respawn_req = 1'b1;
        respawn_idx = IW'(1);
        mode        = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        modelReload();
        checkOutput("abortAck", int'(respawn_ack), 0);
        checkOutput("abortBusy", int'(busy), 0);
        checkTable("abort");
        @(negedge clk);
        start       = 1'b0;
        respawn_req = 1'b0;
        watchNoAck("abortNoAck", 10);
        checkTable("afterAbort");

        @(negedge clk);
        respawn_req = 1'b1;
        respawn_idx = IW'(2);
        mode        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        modelReload();
        checkOutput("rstBusy", int'(busy), 0);
        checkOutput("rstAck", int'(respawn_ack), 0);
        checkTable("rstMid");
        @(negedge clk);
        rst         = 1'b0;
        respawn_req = 1'b0;
        watchNoAck("rstNoAck", 10);

        applyStimulus(2, 1'b0, 1'b0);
        applyStimulus(3, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
